// File: rtl/i2s_tx_serializer_if.sv
// Sample-FIFO and I2S pin bundle for i2s_tx_serializer.
// slave = serializer side, master = FIFO/pad side.
interface i2s_tx_serializer_if;
    logic        i_Enable;
    logic        i_Fifo_Empty;
    logic [31:0] i_Fifo_Data;
    logic        o_Fifo_Rd;
    logic        o_Underrun;
    logic        o_Busy;
    logic        o_I2S_SDIN;
    logic        o_I2S_SCLK;
    logic        o_I2S_LRCK;
    logic        o_I2S_MCLK;

    modport slave (
        input  i_Enable, i_Fifo_Empty, i_Fifo_Data,
        output o_Fifo_Rd, o_Underrun, o_Busy,
        output o_I2S_SDIN, o_I2S_SCLK, o_I2S_LRCK, o_I2S_MCLK
    );

    modport master (
        output i_Enable, i_Fifo_Empty, i_Fifo_Data,
        input  o_Fifo_Rd, o_Underrun, o_Busy,
        input  o_I2S_SDIN, o_I2S_SCLK, o_I2S_LRCK, o_I2S_MCLK
    );
endinterface

// File: rtl/i2s_tx_serializer.sv
// I2S transmitter: pops one 32-bit stereo word per 32-slot frame and shifts it out one slot late.
// Optional macro I2S_UNDERRUN_REPEAT_EN replays the last good word on underrun instead of silence.
module i2s_tx_serializer #(
    parameter int unsigned SCLK_DIV = 4,
    parameter int unsigned MCLK_DIV = 1
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    i2s_tx_serializer_if.slave bus
);

    localparam int unsigned SLOT_CYC = 2 * SCLK_DIV;
    localparam int unsigned DIV_W    = $clog2(SLOT_CYC);
    localparam int unsigned MCLK_W   = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
    localparam int unsigned SLOT_W   = 5;

    localparam logic [DIV_W-1:0]  HALF_LAST = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0]  SLOT_LAST = DIV_W'(SLOT_CYC - 1);
    localparam logic [MCLK_W-1:0] MCLK_LAST = MCLK_W'(MCLK_DIV - 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(31);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e              state_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [SLOT_W-1:0]   slot_q;
    logic [31:0]         word_q;
    logic [MCLK_W-1:0]   mclk_cnt_q;
    logic                mclk_q;
    logic                sclk_q;
    logic                lrck_q;
    logic                sdin_q;
    logic                fifo_rd_q;
    logic                underrun_q;
    logic                busy_q;
    logic [31:0]         fetch_word_d;
    logic [SLOT_W-1:0]   slot_inc_c;

    logic active_c;
    logic slot_end_c;
    logic half_c;
    logic frame_end_c;
    logic start_frame_c;
    logic enter_flush_c;
    logic flush_done_c;

    // Free-running master clock, independent of the serializer state.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            mclk_cnt_q <= '0;
            mclk_q     <= 1'b0;
        end else if (mclk_cnt_q == MCLK_LAST) begin
            mclk_cnt_q <= '0;
            mclk_q     <= ~mclk_q;
        end else begin
            mclk_cnt_q <= mclk_cnt_q + MCLK_W'(1);
        end
    end

`ifdef I2S_UNDERRUN_REPEAT_EN
    logic [31:0] last_q;

    // Last word actually popped, replayed when the FIFO runs dry.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            last_q <= '0;
        end else if (start_frame_c && !bus.i_Fifo_Empty) begin
            last_q <= bus.i_Fifo_Data;
        end
    end

    always_comb begin
        fetch_word_d = last_q;
        if (!bus.i_Fifo_Empty) begin
            fetch_word_d = bus.i_Fifo_Data;
        end
    end
`else
    always_comb begin
        fetch_word_d = 32'h0000_0000;
        if (!bus.i_Fifo_Empty) begin
            fetch_word_d = bus.i_Fifo_Data;
        end
    end
`endif

    assign active_c      = (state_q != ST_IDLE);
    assign slot_end_c    = active_c && (div_cnt_q == SLOT_LAST);
    assign half_c        = active_c && (div_cnt_q == HALF_LAST);
    assign frame_end_c   = (state_q == ST_RUN) && slot_end_c && (slot_q == LAST_SLOT);
    // Enable is only looked at on frame boundaries; mid-frame changes are ignored.
    assign start_frame_c = ((state_q == ST_IDLE) && bus.i_Enable) || (frame_end_c && bus.i_Enable);
    assign enter_flush_c = frame_end_c && !bus.i_Enable;
    assign flush_done_c  = (state_q == ST_FLUSH) && slot_end_c;
    assign slot_inc_c    = slot_q + SLOT_W'(1);

    // Slot sequencer; word_q[31] always holds the bit for the next slot start.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q    <= ST_IDLE;
            div_cnt_q  <= '0;
            slot_q     <= '0;
            word_q     <= '0;
            sclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            sdin_q     <= 1'b0;
            fifo_rd_q  <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fifo_rd_q  <= 1'b0;
            underrun_q <= 1'b0;
            if (start_frame_c) begin
                state_q    <= ST_RUN;
                div_cnt_q  <= '0;
                slot_q     <= '0;
                sclk_q     <= 1'b0;
                lrck_q     <= 1'b0;
                sdin_q     <= word_q[31];
                word_q     <= fetch_word_d;
                fifo_rd_q  <= !bus.i_Fifo_Empty;
                underrun_q <= bus.i_Fifo_Empty;
                busy_q     <= 1'b1;
            end else if (enter_flush_c) begin
                // Trailing slot 0 carries the final right[0]; nothing is fetched.
                state_q   <= ST_FLUSH;
                div_cnt_q <= '0;
                slot_q    <= '0;
                sclk_q    <= 1'b0;
                lrck_q    <= 1'b0;
                sdin_q    <= word_q[31];
                word_q    <= '0;
            end else if (flush_done_c) begin
                state_q   <= ST_IDLE;
                div_cnt_q <= '0;
                slot_q    <= '0;
                word_q    <= '0;
                sclk_q    <= 1'b0;
                lrck_q    <= 1'b0;
                sdin_q    <= 1'b0;
                busy_q    <= 1'b0;
            end else if (slot_end_c) begin
                div_cnt_q <= '0;
                slot_q    <= slot_inc_c;
                sclk_q    <= 1'b0;
                lrck_q    <= slot_inc_c[4];
                sdin_q    <= word_q[31];
                word_q    <= {word_q[30:0], 1'b0};
            end else if (active_c) begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
                if (half_c) begin
                    sclk_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_Fifo_Rd  = fifo_rd_q;
    assign bus.o_Underrun = underrun_q;
    assign bus.o_Busy     = busy_q;
    assign bus.o_I2S_SDIN = sdin_q;
    assign bus.o_I2S_SCLK = sclk_q;
    assign bus.o_I2S_LRCK = lrck_q;
    assign bus.o_I2S_MCLK = mclk_q;

endmodule

// File: doc/i2s_tx_serializer.md
I2S_TX_SERIALIZER -- requirements
Module: i2s_tx_serializer

Interface
REQ-001 SHALL have parameter SCLK_DIV, default 4, meaning i_Clk cycles per SCLK half-period (>=2).
REQ-002 SHALL have parameter MCLK_DIV, default 1, meaning i_Clk cycles per MCLK half-period (>=1).
REQ-003 SHALL have port i_Clk  in  1  audio clock; the only clock.
REQ-004 SHALL have port i_Rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_Enable  in  1  run request.
REQ-006 SHALL have port i_Fifo_Empty  in  1  upstream sample FIFO empty.
REQ-007 SHALL have port i_Fifo_Data  in  32  FWFT head word, [31:16] left, [15:0] right.
REQ-008 SHALL have port o_Fifo_Rd  out  1  one-cycle pop strobe.
REQ-009 SHALL have port o_Underrun  out  1  one-cycle pulse on a fetch with the FIFO empty.
REQ-010 SHALL have port o_Busy  out  1  high in RUN or FLUSH.
REQ-011 SHALL have ports o_I2S_SDIN, o_I2S_SCLK, o_I2S_LRCK, o_I2S_MCLK  out  1 each  I2S serial data, bit clock, word select, master clock.

Function
REQ-012 SHALL toggle o_I2S_MCLK every MCLK_DIV cycles whenever reset is deasserted, independent of state.
REQ-013 SHALL implement states IDLE, RUN and FLUSH.
REQ-014 IDLE: SCLK, LRCK and SDIN low; no reads; i_Enable=1 enters RUN next cycle at slot 0 with SCLK low.
REQ-015 SCLK SHALL toggle every SCLK_DIV cycles in RUN/FLUSH; each slot spans one SCLK period starting on a falling edge (or on RUN entry).
REQ-016 A frame SHALL contain slots 0..31; LRCK low in slots 0..15 and high in slots 16..31; all outputs change only at slot starts.
REQ-017 SDIN SHALL be delayed one slot: slots 1..16 carry left[15:0] MSB-first, slots 17..31 carry right[15:1], and slot 0 of the next frame carries right[0].
REQ-018 Slot 0 of the first frame after IDLE SHALL drive SDIN=0.
REQ-019 Fetch SHALL occur in the first cycle of slot 0: if not empty, o_Fifo_Rd=1 for exactly that cycle and i_Fifo_Data is captured in the same cycle.
REQ-020 Fetch with i_Fifo_Empty=1 SHALL produce no pop, a one-cycle o_Underrun, and a frame whose word is 0x00000000.
REQ-021 i_Enable SHALL be sampled only at the end of slot 31; if low, the block SHALL enter FLUSH instead of starting a new frame.
REQ-022 FLUSH SHALL output one slot 0 (LRCK low, SDIN=right[0], no fetch), then enter IDLE.
REQ-023 Deassert and reassert of i_Enable mid-frame SHALL have no effect.
REQ-024 A fetch coinciding with a disable SHALL be suppressed: no pop, no underrun.

Reset
REQ-025 Assertion SHALL immediately force all outputs to 0, state to IDLE, and clear all counters and the shift/delay registers.
REQ-026 Reset mid-frame SHALL abandon the frame; any popped word is lost.
REQ-027 After release, MCLK SHALL start low and toggle first after MCLK_DIV cycles.

Configuration
REQ-028 Macro I2S_UNDERRUN_REPEAT_EN, when defined, SHALL make an underrun frame replay the last successfully fetched word (0 if none since reset).
REQ-029 Without I2S_UNDERRUN_REPEAT_EN, an underrun frame SHALL be all zeros per REQ-020; o_Underrun behaviour SHALL be identical in both builds.

Verification (SCLK_DIV=2, MCLK_DIV=1)
REQ-030 Reset, then i_Enable=0 for 100 cycles -> MCLK period 2 cycles; SCLK/LRCK/SDIN/o_Busy/o_Fifo_Rd stay 0.
REQ-031 FIFO holds 0xA5A53C3C; enable -> one pop in the first RUN cycle; slots 1..16 SDIN=1010010110100101, slots 17..31 bits 15..1 of 0x3C3C, next slot 0 SDIN=0; SCLK period 4 cycles; frame 128 cycles.
REQ-032 FIFO empty at the second fetch -> o_Underrun one cycle, no pop, frame SDIN all 0; with I2S_UNDERRUN_REPEAT_EN, frame repeats 0xA5A53C3C.
REQ-033 i_Enable dropped at slot 5 of a frame with right word 0x0001 -> frame completes, FLUSH slot SDIN=1 with LRCK low, then IDLE; no further pop.
REQ-034 i_Rst_n pulsed low at slot 20 -> all outputs 0 in the same cycle; after release with i_Enable=1, a new frame starts at slot 0 with a fresh pop.
